// File: rtl/clint_pkg.sv
// Shared constants, state encodings and small helpers for the AXI CLINT.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Result of decoding one beat address against the CLINT window.
  typedef enum logic [2:0] {SEL_ZERO, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME, SEL_OOW} sel_t;

  function automatic logic [63:0] byte_merge(input logic [63:0] cur,
                                             input logic [63:0] wd,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = cur;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = wd[i*8 +: 8];
    end
    return res;
  endfunction

  // Anything other than INCR (FIXED, and WRAP which is not supported) holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

endpackage

// File: rtl/axi_clint_if.sv
// AXI4 bus (64-bit data) between the core master port and the CLINT slave.
// Handshake: a beat transfers on the rising edge where valid && ready; valid must
// hold with stable payload until that edge, and ready may be asserted independently.
interface axi_clint_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/clint_timer.sv
// mtime prescaler/counter, mtimecmp storage with byte-merge write ports, and the
// registered mti compare taken on the post-update values.
module clint_timer
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] wdata,
  input  logic [7:0]  mtime_be,
  input  logic [7:0]  mtimecmp_be,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mti
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime_d;
  logic [63:0]   mtimecmp_d;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // A software write to mtime wins over a tick; partial strobes merge with the
  // current, un-incremented count.
  always_comb begin
    mtime_d = mtime;
    if (|mtime_be)  mtime_d = byte_merge(mtime, wdata, mtime_be);
    else if (tick)  mtime_d = mtime + 64'd1;
    mtimecmp_d = byte_merge(mtimecmp, wdata, mtimecmp_be);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      mti      <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      mtime    <= mtime_d;
      mtimecmp <= mtimecmp_d;
      mti      <= (mtime_d >= mtimecmp_d);
    end
  end

endmodule

// File: rtl/axi_clint.sv
// Single-hart AXI4 CLINT: independent read and write channel FSMs, address decode
// of the 64 KiB window, msip storage, and the timer sub-block.
module axi_clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1,
  parameter int          ID_W      = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  axi_clint_if.slave   bus,
  output logic         msi,
  output logic         mti
);

  function automatic sel_t decode(input logic [31:0] addr);
    logic [31:0] off;
    sel_t        sel;
    off = addr - BASE_ADDR;
    sel = SEL_ZERO;
    if (addr < BASE_ADDR || off > 32'h0000_FFFF) begin
      sel = SEL_OOW;
    end else begin
      case ({off[15:3], 3'b000})
        MSIP_OFF:     sel = SEL_MSIP;
        MTIMECMP_OFF: sel = SEL_MTIMECMP;
        MTIME_OFF:    sel = SEL_MTIME;
        default:      sel = SEL_ZERO;
      endcase
    end
    return sel;
  endfunction

  logic        live;      // keeps ready low while in reset, high from the first clock after
  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  // ---------------- read channel ----------------
  r_state_t        r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [7:0]      r_len, r_beat;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            ar_hs, r_hs;
  sel_t            r_sel;
  logic [63:0]     r_mux;

  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = bus.rvalid && bus.rready;
  assign r_sel = decode(r_addr);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && bus.rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    r_mux = 64'd0;
    case (r_sel)
      SEL_MSIP:     r_mux = {63'd0, msip};
      SEL_MTIMECMP: r_mux = mtimecmp;
      SEL_MTIME:    r_mux = mtime;
      default:      r_mux = 64'd0;
    endcase
  end

  always_comb begin
    bus.arready = live && (r_state == R_IDLE);
    bus.rvalid  = (r_state == R_DATA);
    bus.rdata   = r_mux;
    bus.rresp   = (r_sel == SEL_OOW) ? RESP_DECERR : RESP_OKAY;
    bus.rlast   = (r_state == R_DATA) && (r_beat == r_len);
    bus.rid     = r_id;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= BURST_FIXED;
    end else if (ar_hs) begin
      r_id    <= bus.arid;
      r_addr  <= bus.araddr;
      r_len   <= bus.arlen;
      r_beat  <= 8'd0;
      r_size  <= bus.arsize;
      r_burst <= bus.arburst;
    end else if (r_hs) begin
      r_beat  <= r_beat + 8'd1;
      r_addr  <= next_addr(r_addr, r_size, r_burst);
    end
  end

  // ---------------- write channel ----------------
  w_state_t        w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic            w_err;
  logic            aw_hs, w_hs, b_hs;
  sel_t            w_sel;
  logic [7:0]      mtime_be, mtimecmp_be;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bus.bvalid && bus.bready;
  assign w_sel = decode(w_addr);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && bus.wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = live && (w_state == W_IDLE);
    bus.wready  = (w_state == W_DATA);
    bus.bvalid  = (w_state == W_RESP);
    bus.bresp   = w_err ? RESP_DECERR : RESP_OKAY;
    bus.bid     = w_id;
  end

  // w_err accumulates across the burst so one stray beat poisons the response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= 32'd0;
      w_size  <= 3'd0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= bus.awid;
      w_addr  <= bus.awaddr;
      w_size  <= bus.awsize;
      w_burst <= bus.awburst;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
      w_err   <= w_err | (w_sel == SEL_OOW);
    end
  end

  assign mtime_be    = (w_hs && w_sel == SEL_MTIME)    ? bus.wstrb : 8'h00;
  assign mtimecmp_be = (w_hs && w_sel == SEL_MTIMECMP) ? bus.wstrb : 8'h00;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live <= 1'b0;
      msip <= 1'b0;
    end else begin
      live <= 1'b1;
      if (w_hs && w_sel == SEL_MSIP && bus.wstrb[0]) msip <= bus.wdata[0];
    end
  end

  assign msi = msip;

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk         (aclk),
    .rst_n       (aresetn),
    .wdata       (bus.wdata),
    .mtime_be    (mtime_be),
    .mtimecmp_be (mtimecmp_be),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .mti         (mti)
  );

endmodule

// File: tb/tb_axi_clint.sv
// Self-checking bench for axi_clint: directed scenarios plus randomized bursts,
// all checked against a register-level reference model of the CLINT.
module tb_axi_clint;

  localparam logic [31:0] BASE     = 32'h0200_0000;
  localparam int          TICK_DIV = 1;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic msi, mti;

  axi_clint_if #(.ID_W(4)) bus();

  axi_clint #(.BASE_ADDR(BASE), .TICK_DIV(TICK_DIV), .ID_W(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .msi     (msi),
    .mti     (mti)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime = 64'd0;
  logic [63:0] m_cmp   = '1;
  logic        m_msip  = 1'b0;
  int          m_cyc   = 0;
  logic        pend    = 1'b0;   // a W beat transfers on the coming edge
  logic [31:0] pend_addr;
  logic [63:0] pend_data;
  logic [7:0]  pend_strb;

  function automatic int region(input logic [31:0] a);
    if (a < BASE || a > BASE + 32'h0000_FFFF) return -1;
    return int'((a - BASE) & 32'h0000_FFF8);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // {resp, data} the slave should return for a beat at address a right now.
  function automatic logic [65:0] model_read(input logic [31:0] a);
    int r;
    r = region(a);
    if (r < 0)           return {2'b11, 64'd0};
    if (r == 0)          return {2'b00, 63'd0, m_msip};
    if (r == 'h4000)     return {2'b00, m_cmp};
    if (r == 'hBFF8)     return {2'b00, m_mtime};
    return {2'b00, 64'd0};
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_mtime = 64'd0;
      m_cmp   = '1;
      m_msip  = 1'b0;
      m_cyc   = 0;
      pend    = 1'b0;
    end else begin
      logic tick;
      int   r;
      tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc++;
      r = pend ? region(pend_addr) : -2;
      if (r == 'hBFF8)  m_mtime = merge(m_mtime, pend_data, pend_strb);
      else if (tick)    m_mtime = m_mtime + 64'd1;
      if (r == 'h4000)  m_cmp = merge(m_cmp, pend_data, pend_strb);
      if (r == 0 && pend_strb[0]) m_msip = pend_data[0];
      pend = 1'b0;
    end
  end

  // Interrupt outputs are compared every cycle against the model.
  bit mon_en = 0;
  always @(negedge aclk) begin
    if (mon_en) begin
      check_eq("mti", mti, (m_mtime >= m_cmp));
      check_eq("msi", msi, m_msip);
    end
  end

  // ---------------- drivers ----------------
  bit          stall_en = 0;
  logic [63:0] wr_data[$];
  logic [7:0]  wr_strb[$];

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst);
    logic [31:0] a;
    logic        exp_err;
    int          t;
    a = addr;
    exp_err = 1'b0;
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = 3'd3; bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 100) begin @(negedge aclk); t++; end
    check_eq("awready", bus.awready, 1);
    @(posedge aclk);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (stall_en) repeat ($urandom_range(0, 2)) @(negedge aclk);
      bus.wdata = wr_data[b]; bus.wstrb = wr_strb[b];
      bus.wlast = (b == len); bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 100) begin @(negedge aclk); t++; end
      check_eq("wready", bus.wready, 1);
      pend_addr = a; pend_data = wr_data[b]; pend_strb = wr_strb[b]; pend = 1'b1;
      if (region(a) < 0) exp_err = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      a = (burst == 2'b01) ? a + 32'd8 : a;
    end
    t = 0;
    while (!bus.bvalid && t < 100) begin @(negedge aclk); t++; end
    check_eq("bvalid", bus.bvalid, 1);
    check_eq("bresp", bus.bresp, exp_err ? 2'b11 : 2'b00);
    check_eq("bid", bus.bid, id);
    bus.bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bus.bready = 1'b0;
    check_eq("b_done", bus.bvalid, 0);
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] s);
    wr_data = {d};
    wr_strb = {s};
    do_write(4'($urandom_range(0, 15)), addr, 0, 2'b01);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, output logic [63:0] last_d);
    logic [31:0] a;
    logic [65:0] e;
    int          t, b;
    a = addr;
    last_d = 64'd0;
    @(negedge aclk);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = 3'd3; bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 100) begin @(negedge aclk); t++; end
    check_eq("arready", bus.arready, 1);
    @(posedge aclk);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check_eq("r_latency", bus.rvalid, 1);
    b = 0; t = 0;
    while (b <= len && t < 200) begin
      bus.rready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.rvalid && bus.rready) begin
        e = model_read(a);
        check_eq("rdata", bus.rdata, e[63:0]);
        check_eq("rresp", bus.rresp, e[65:64]);
        check_eq("rlast", bus.rlast, (b == len));
        check_eq("rid", bus.rid, id);
        last_d = bus.rdata;
        b++;
        a = (burst == 2'b01) ? a + 32'd8 : a;
      end
      @(negedge aclk);
      t++;
    end
    bus.rready = 1'b0;
    check_eq("r_beats", b, len + 1);
    check_eq("r_done", bus.rvalid, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] addr_tbl[6] = '{32'h0200_0000, 32'h0200_4000, 32'h0200_BFF8,
                               32'h0200_1230, 32'h0300_0000, 32'h0200_FFF0};

  initial begin
    logic [63:0] d;
    int          t;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arvalid = 0;
    bus.rready = 0;

    // Reset and idle: mtime counts from 0 once released.
    repeat (3) @(negedge aclk);
    check_eq("rst_bvalid", bus.bvalid, 0);
    check_eq("rst_rvalid", bus.rvalid, 0);
    check_eq("rst_awready", bus.awready, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    mon_en = 1;
    check_eq("idle_awready", bus.awready, 1);
    check_eq("idle_arready", bus.arready, 1);
    check_eq("idle_mti", mti, 0);
    repeat (7) @(negedge aclk);
    do_read(4'h1, BASE + 32'hBFF8, 0, 2'b01, d);
    check_eq("mtime_9_to_11", (d >= 64'd9 && d <= 64'd11), 1);

    // mtimecmp = 20: mti rises together with mtime reaching 20, then cleared.
    wr1(BASE + 32'h4000, 64'd20, 8'hFF);
    t = 0;
    while (!mti && t < 50) begin @(negedge aclk); t++; end
    check_eq("mti_rise", mti, 1);
    check_eq("mti_at_20", m_mtime, 64'd20);
    wr1(BASE + 32'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check_eq("mti_clear", mti, 0);

    // msip set, read back, clear.
    wr1(BASE, 64'h1, 8'h0F);
    check_eq("msi_set", msi, 1);
    do_read(4'h2, BASE, 0, 2'b01, d);
    check_eq("msip_read", d, 64'h1);
    wr1(BASE, 64'h0, 8'hFF);
    check_eq("msi_clear", msi, 0);

    // 2-beat INCR write then read at mtimecmp; second beat is unmapped.
    wr_data = {64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0000_0001};
    wr_strb = {8'hFF, 8'hFF};
    do_write(4'h3, BASE + 32'h4000, 1, 2'b01);
    do_read(4'h4, BASE + 32'h4000, 1, 2'b01, d);
    check_eq("incr_beat1_zero", d, 64'd0);

    // Out-of-window read and write: DECERR, no state change.
    do_read(4'h5, 32'h0300_0000, 0, 2'b01, d);
    wr1(32'h0300_0000, 64'h5555_5555_5555_5555, 8'hFF);
    do_read(4'h6, BASE + 32'h4000, 0, 2'b01, d);
    check_eq("cmp_untouched", d, 64'h1234_5678_9ABC_DEF0);

    // mtime writes: full value wins over the tick, partial strobes merge.
    wr1(BASE + 32'hBFF8, 64'h0000_0001_0000_0000, 8'hFF);
    wr1(BASE + 32'hBFF8, 64'hAA00_0000_0000_0000, 8'h80);
    do_read(4'h7, BASE + 32'hBFF8, 0, 2'b00, d);

    // Randomized bursts with back-pressure.
    stall_en = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          len;
      logic [1:0]  br;
      a   = addr_tbl[$urandom_range(0, 5)];
      len = $urandom_range(0, 3);
      br  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
      if ($urandom_range(0, 1) != 0) begin
        wr_data = {};
        wr_strb = {};
        for (int b = 0; b <= len; b++) begin
          wr_data.push_back({$urandom, $urandom});
          wr_strb.push_back(8'($urandom_range(0, 255)));
        end
        do_write(4'($urandom_range(0, 15)), a, len, br);
      end else begin
        do_read(4'($urandom_range(0, 15)), a, len, br, d);
      end
    end
    stall_en = 0;

    // Reset in the middle of a 4-beat write: no response afterwards.
    @(negedge aclk);
    bus.awid = 4'h9; bus.awaddr = BASE + 32'h4000; bus.awlen = 8'd3;
    bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    check_eq("mr_awready", bus.awready, 1);
    @(posedge aclk);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.wdata = 64'h0BAD_0000_0000_0000 + 64'(b); bus.wstrb = 8'hFF; bus.wlast = 1'b0;
      bus.wvalid = 1'b1;
      check_eq("mr_wready", bus.wready, 1);
      pend_addr = BASE + 32'h4000 + 32'(8 * b); pend_data = bus.wdata; pend_strb = 8'hFF;
      pend = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
    end
    #2;
    aresetn = 1'b0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    repeat (2) @(negedge aclk);
    check_eq("mr_bvalid_in_reset", bus.bvalid, 0);
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("mr_bvalid", bus.bvalid, 0);
    end
    bus.bready = 1'b0;
    check_eq("mr_awready_after", bus.awready, 1);
    do_read(4'hA, BASE + 32'h4000, 0, 2'b01, d);
    check_eq("mr_cmp_ones", d, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(4'hB, BASE + 32'hBFF8, 0, 2'b01, d);
    check_eq("mr_mtime_small", (d < 64'd16), 1);

    repeat (3) @(negedge aclk);
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
